scan_sequencer: RTL

- Sequences the raster scan that feeds the stream packer. It replaces the free-running x/y counters in the test-pattern generator with a controlled scanner.
- Generates pixel coordinates, sof/eol and valid under run/stop/single-frame/abort control.
- Advances the animation frame value at each frame boundary.
- Sits between the AXI-Lite control register file, whose fields are resynchronised to this clock upstream, and the packer's input handshake.

---
 rtl/scan_sequencer_if.sv | 23 ++
 rtl/scan_sequencer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/scan_sequencer_if.sv
// Pixel-stream handshake between the raster scanner and the stream packer.
// The scanner drives coordinates, framing flags and valid; the packer returns ready.
interface scan_sequencer_if #(
   parameter int XW = 10,
   parameter int YW = 9
);
   logic          pix_valid;
   logic          pix_ready;
   logic [XW-1:0] pix_x;
   logic [YW-1:0] pix_y;
   logic          pix_sof;
   logic          pix_eol;

   modport master (
      output pix_valid, pix_x, pix_y, pix_sof, pix_eol,
      input  pix_ready
   );

   modport slave (
      input  pix_valid, pix_x, pix_y, pix_sof, pix_eol,
      output pix_ready
   );
endinterface

// File: rtl/scan_sequencer.sv
// Controlled raster scanner: walks x/y over the frame under run/single/abort
// control, holds each beat until accepted and advances the animation frame value.
module scan_sequencer #(
   parameter int X_SIZE = 640,
   parameter int Y_SIZE = 480,
   parameter int XW     = 10,
   parameter int YW     = 9
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic        ctrl_run,
   input  logic        ctrl_single,
   input  logic        ctrl_abort,
   input  logic        ctrl_frame_load,
   input  logic [7:0]  ctrl_frame_init,
   input  logic [7:0]  ctrl_frame_step,
   scan_sequencer_if.master pix,
   output logic [7:0]  frame,
   output logic        busy,
   output logic        frame_done,
   output logic [15:0] frame_count
);

   typedef enum logic {IDLE, SCAN} state_e;

   localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

   state_e        state_q, state_d;
   logic          valid_q, valid_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [7:0]    frame_q, frame_d;
   logic          done_q, done_d;
   logic [15:0]   count_q, count_d;
   logic          single_pend_q, single_pend_d;
   logic          abort_pend_q, abort_pend_d;
   logic          load_pend_q, load_pend_d;
   logic [7:0]    init_latched_q, init_latched_d;

   logic eol, accept, last;

   assign eol    = (x_q == X_LAST);
   assign accept = valid_q && pix.pix_ready;
   assign last   = eol && (y_q == Y_LAST);

   // NOTE: every _d gets its hold value first so no path through the case leaves it unassigned (no latches).
   always_comb begin
      state_d        = state_q;
      valid_d        = valid_q;
      x_d            = x_q;
      y_d            = y_q;
      frame_d        = frame_q;
      done_d         = 1'b0;
      count_d        = count_q;
      single_pend_d  = single_pend_q;
      abort_pend_d   = abort_pend_q;
      load_pend_d    = load_pend_q;
      init_latched_d = init_latched_q;

      case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            if (ctrl_frame_load) frame_d = ctrl_frame_init;
            if (ctrl_run || ctrl_single || single_pend_q) begin
               state_d       = SCAN;
               valid_d       = 1'b1;
               x_d           = '0;
               y_d           = '0;
               single_pend_d = 1'b0;
            end
         end

         SCAN: begin
            if (ctrl_frame_load) begin
               init_latched_d = ctrl_frame_init;
               load_pend_d    = 1'b1;
            end
            if (ctrl_single) single_pend_d = 1'b1;
            if (ctrl_abort)  abort_pend_d  = 1'b1;

            if (accept) begin
               if (last) begin
                  x_d     = '0;
                  y_d     = '0;
                  done_d  = 1'b1;
                  count_d = count_q + 16'd1;
                  frame_d = load_pend_q ? init_latched_q : frame_q + ctrl_frame_step;
                  // A load arriving on the boundary cycle stays pending for the next frame.
                  load_pend_d = ctrl_frame_load;
               end else if (eol) begin
                  x_d = '0;
                  y_d = y_q + 1'b1;
               end else begin
                  x_d = x_q + 1'b1;
               end

               if (abort_pend_q || ctrl_abort) begin
                  state_d       = IDLE;
                  valid_d       = 1'b0;
                  x_d           = '0;
                  y_d           = '0;
                  abort_pend_d  = 1'b0;
                  single_pend_d = 1'b0;
               end else if (last && !ctrl_run) begin
                  if (single_pend_q || ctrl_single) begin
                     single_pend_d = 1'b0;
                  end else begin
                     state_d = IDLE;
                     valid_d = 1'b0;
                  end
               end
            end
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q        <= IDLE;
         valid_q        <= 1'b0;
         x_q            <= '0;
         y_q            <= '0;
         frame_q        <= 8'd0;
         done_q         <= 1'b0;
         count_q        <= 16'd0;
         single_pend_q  <= 1'b0;
         abort_pend_q   <= 1'b0;
         load_pend_q    <= 1'b0;
         init_latched_q <= 8'd0;
      end else begin
         state_q        <= state_d;
         valid_q        <= valid_d;
         x_q            <= x_d;
         y_q            <= y_d;
         frame_q        <= frame_d;
         done_q         <= done_d;
         count_q        <= count_d;
         single_pend_q  <= single_pend_d;
         abort_pend_q   <= abort_pend_d;
         load_pend_q    <= load_pend_d;
         init_latched_q <= init_latched_d;
      end
   end

   assign pix.pix_valid = valid_q;
   assign pix.pix_x     = x_q;
   assign pix.pix_y     = y_q;
   assign pix.pix_sof   = (x_q == '0) && (y_q == '0);
   assign pix.pix_eol   = eol;

   assign frame       = frame_q;
   assign busy        = (state_q == SCAN);
   assign frame_done  = done_q;
   assign frame_count = count_q;

endmodule
